// File: rtl/fp32_pkg.sv
// fp32_pkg
// Shared definitions for the FP32 dot-product accumulator:
//   - FP32 field widths, bias and canonical special encodings
//   - FSM state encoding (IDLE/ALIGN/ADD/NORM/OUT)
//   - fp32_t field view and a small operand classifier
// Numeric policy: denormals flush to zero, no rounding (truncate).
package fp32_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MAN_W    = FRAC_W + 1;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_NORM  = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    // exp==0 is treated as zero regardless of frac (denormals flushed).
    function automatic fp_class_t fp_classify(input fp32_t v);
        fp_class_t c;
        c.is_zero = (v.exp == '0);
        c.is_inf  = (v.exp == '1) && (v.frac == '0);
        c.is_nan  = (v.exp == '1) && (v.frac != '0);
        return c;
    endfunction

endpackage

// File: rtl/fp32_lzc24.sv
// fp32_lzc24
// Combinational leading-zero count of a 24-bit mantissa.
// Ports:
//   i_data   in  24  mantissa to examine
//   o_count  out 5   number of leading zeros (24 when i_data is zero)
module fp32_lzc24
    import fp32_pkg::*;
(
    input  logic [MAN_W-1:0] i_data,
    output logic [4:0]       o_count
);

    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        o_count = 5'd24;
        for (int i = 0; i < MAN_W; i++) begin
            if (i_data[i]) begin
                o_count = 5'(MAN_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_dot_accum.sv
// fp32_dot_accum
// Sequential FP32 accumulator behind the TF32 multiplier. Accepts one FP32
// product per handshake, runs it through ALIGN -> ADD -> NORM (one term every
// four cycles) and, after NTERMS products, presents the sum with valid/ready.
// Denormals flush to zero; alignment and normalization truncate.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   product available
//   in_ready   out  1   high only in IDLE
//   in_data    in   32  FP32 product
//   out_valid  out  1   result available, held until out_ready
//   out_ready  in   1   consumer takes result
//   out_data   out  32  FP32 sum of NTERMS products
// Optional (macro FP32_ACC_FLAGS_EN):
//   out_nan, out_inf, out_uf  out 1 each; sticky over one dot product,
//   valid with out_valid, cleared on result handshake or reset.
module fp32_dot_accum
    import fp32_pkg::*;
#(
    parameter int NTERMS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
`ifdef FP32_ACC_FLAGS_EN
    ,
    output logic        out_nan,
    output logic        out_inf,
    output logic        out_uf
`endif
);

    localparam int               CNT_W    = $clog2(NTERMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NTERMS);

    // Control state (reset)
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_acc;
    logic             r_out_valid;
    logic [31:0]      r_out_data;

    // Datapath staging (not reset)
    logic [31:0]              r_in_p0;
    logic                     r_spec_p1;
    logic [31:0]              r_spec_val_p1;
    logic                     r_sign_p1;
    logic                     r_sub_p1;
    logic signed [9:0]        r_exp_p1;
    logic [MAN_W-1:0]         r_man_a_p1;
    logic [MAN_W-1:0]         r_man_b_p1;
    logic [MAN_W:0]           r_sum_p2;

    // Saturating pack of a normalized result: overflow -> signed inf,
    // underflow -> signed zero, zero mantissa -> +0.
    function automatic logic [31:0] sat_pack(input logic              sign,
                                             input logic signed [9:0] exp,
                                             input logic [FRAC_W-1:0] frac,
                                             input logic              zero);
        if (zero) begin
            return 32'h0000_0000;
        end else if (exp >= 10'sd255) begin
            return sign ? NEG_INF : POS_INF;
        end else if (exp <= 10'sd0) begin
            return {sign, 31'd0};
        end
        return {sign, exp[EXP_W-1:0], frac};
    endfunction

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // ---- ALIGN: classify, resolve specials, order operands, shift smaller ----
    fp32_t            w_acc;
    fp32_t            w_term;
    fp_class_t        w_acc_cls;
    fp_class_t        w_term_cls;
    logic [30:0]      w_acc_mag;
    logic             w_acc_big;
    fp32_t            w_big;
    fp32_t            w_small;
    logic [EXP_W-1:0] w_exp_diff;
    logic [MAN_W-1:0] w_man_small;
    logic [MAN_W-1:0] w_man_shift;
    logic             w_spec;
    logic [31:0]      w_spec_val;

    assign w_acc  = r_acc;
    assign w_term = r_in_p0;

    always_comb begin
        w_acc_cls  = fp_classify(w_acc);
        w_term_cls = fp_classify(w_term);

        // A zero accumulator must lose the magnitude compare to any live term.
        w_acc_mag  = w_acc_cls.is_zero ? 31'd0 : r_acc[30:0];
        w_acc_big  = (w_acc_mag > r_in_p0[30:0]);
        w_big      = w_acc_big ? w_acc  : w_term;
        w_small    = w_acc_big ? w_term : w_acc;

        // On the non-special path the larger operand is never zero.
        w_exp_diff  = w_big.exp - w_small.exp;
        w_man_small = (w_small.exp == '0) ? '0 : {1'b1, w_small.frac};
        w_man_shift = (w_exp_diff >= 8'd25) ? '0 : (w_man_small >> w_exp_diff);

        w_spec     = 1'b1;
        w_spec_val = r_acc;
        if (w_acc_cls.is_nan || w_term_cls.is_nan ||
            (w_acc_cls.is_inf && w_term_cls.is_inf && (w_acc.sign != w_term.sign))) begin
            w_spec_val = QNAN;
        end else if (w_acc_cls.is_inf) begin
            w_spec_val = r_acc;
        end else if (w_term_cls.is_inf) begin
            w_spec_val = w_term.sign ? NEG_INF : POS_INF;
        end else if (w_term_cls.is_zero) begin
            // Zero term leaves the accumulator (including a -0) untouched.
            w_spec_val = r_acc;
        end else begin
            w_spec = 1'b0;
        end
    end

    // ---- ADD: 25-bit magnitude add or subtract, sign follows A ----
    logic [MAN_W:0] w_sum;

    always_comb begin
        if (r_sub_p1) begin
            w_sum = {1'b0, r_man_a_p1} - {1'b0, r_man_b_p1};
        end else begin
            w_sum = {1'b0, r_man_a_p1} + {1'b0, r_man_b_p1};
        end
    end

    // ---- NORM: carry shift or LZC shift, then saturate and pack ----
    logic [4:0]        w_lz;
    logic signed [9:0] w_norm_exp;
    logic [FRAC_W-1:0] w_norm_frac;
    logic              w_norm_zero;
    logic [31:0]       w_result;
    logic [CNT_W-1:0]  w_cnt_inc;

    fp32_lzc24 u_lzc (
        .i_data  (r_sum_p2[MAN_W-1:0]),
        .o_count (w_lz)
    );

    always_comb begin
        w_norm_zero = (r_sum_p2 == '0);
        if (r_sum_p2[MAN_W]) begin
            w_norm_frac = r_sum_p2[MAN_W-1:1];
            w_norm_exp  = r_exp_p1 + 10'sd1;
        end else begin
            // Shifting only the fraction bits drops the leading one that
            // lands in the hidden-bit position.
            w_norm_frac = r_sum_p2[FRAC_W-1:0] << w_lz;
            w_norm_exp  = r_exp_p1 - $signed({5'd0, w_lz});
        end
        w_result = r_spec_p1 ? r_spec_val_p1
                             : sat_pack(r_sign_p1, w_norm_exp, w_norm_frac, w_norm_zero);
    end

    assign w_cnt_inc = r_count + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: r_state <= ST_ADD;
                ST_ADD:   r_state <= ST_NORM;
                ST_NORM: begin
                    r_acc   <= w_result;
                    r_count <= w_cnt_inc;
                    if (w_cnt_inc == CNT_LAST) begin
                        r_state     <= ST_OUT;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_result;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && in_valid) begin
            r_in_p0 <= in_data;
        end
        if (r_state == ST_ALIGN) begin
            r_spec_p1     <= w_spec;
            r_spec_val_p1 <= w_spec_val;
            r_sign_p1     <= w_big.sign;
            r_sub_p1      <= (w_big.sign != w_small.sign);
            r_exp_p1      <= $signed({2'b00, w_big.exp});
            r_man_a_p1    <= {1'b1, w_big.frac};
            r_man_b_p1    <= w_man_shift;
        end
        if (r_state == ST_ADD) begin
            r_sum_p2 <= w_sum;
        end
    end

`ifdef FP32_ACC_FLAGS_EN
    logic r_flag_nan;
    logic r_flag_inf;
    logic r_flag_uf;
    logic w_res_nan;
    logic w_res_inf;
    logic w_res_uf;

    assign w_res_nan = (w_result[30:23] == 8'hFF) && (w_result[22:0] != '0);
    assign w_res_inf = (w_result[30:23] == 8'hFF) && (w_result[22:0] == '0);
    assign w_res_uf  = !r_spec_p1 && !w_norm_zero && (w_norm_exp <= 10'sd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_nan <= 1'b0;
            r_flag_inf <= 1'b0;
            r_flag_uf  <= 1'b0;
        end else if (r_state == ST_NORM) begin
            r_flag_nan <= r_flag_nan | w_res_nan;
            r_flag_inf <= r_flag_inf | w_res_inf;
            r_flag_uf  <= r_flag_uf  | w_res_uf;
        end else if ((r_state == ST_OUT) && out_ready) begin
            r_flag_nan <= 1'b0;
            r_flag_inf <= 1'b0;
            r_flag_uf  <= 1'b0;
        end
    end

    assign out_nan = r_flag_nan;
    assign out_inf = r_flag_inf;
    assign out_uf  = r_flag_uf;
`endif

endmodule

// File: tb/tb_fp32_dot_accum.sv
module tb_fp32_dot_accum;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef FP32_ACC_FLAGS_EN
    logic        out_nan;
    logic        out_inf;
    logic        out_uf;
`endif

    int nchk  = 0;
    int npass = 0;
    logic [2:0] cap_fl;

    fp32_dot_accum #(.NTERMS(NT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FP32_ACC_FLAGS_EN
        ,
        .out_nan   (out_nan),
        .out_inf   (out_inf),
        .out_uf    (out_uf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    // Reference: value-level truncating FP32 add with FTZ and special rules.
    typedef struct packed {
        logic [31:0] v;
        logic        uf;
    } ref_t;

    function automatic ref_t ref_add(input logic [31:0] a, input logic [31:0] t);
        ref_t   r;
        int     ea, et, e, d;
        longint ma, mt, s, mag;
        bit     a_nan, a_inf, t_nan, t_inf, neg;
        int unsigned ka, kt;
        r.uf  = 1'b0;
        r.v   = a;
        ea    = int'(a[30:23]);
        et    = int'(t[30:23]);
        a_nan = (ea == 255) && (a[22:0] != 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        t_nan = (et == 255) && (t[22:0] != 0);
        t_inf = (et == 255) && (t[22:0] == 0);
        if (a_nan || t_nan || (a_inf && t_inf && (a[31] != t[31]))) begin
            r.v = 32'h7FC00000;
            return r;
        end
        if (a_inf) return r;
        if (t_inf) begin r.v = t; return r; end
        if (et == 0) return r;
        ma = (ea == 0) ? 0 : (longint'(a[22:0]) + 64'd8388608);
        mt = longint'(t[22:0]) + 64'd8388608;
        if (a[31]) ma = -ma;
        if (t[31]) mt = -mt;
        ka = (ea == 0) ? 0 : int'(a[30:0]);
        kt = int'(t[30:0]);
        if (ka > kt) begin
            e = ea; d = ea - et;
            s = ma + ((d >= 25) ? 0 : ((mt < 0) ? -((-mt) >> d) : (mt >> d)));
        end else begin
            e = et; d = et - ea;
            s = mt + ((d >= 25 || ea == 0) ? 0 : ((ma < 0) ? -((-ma) >> d) : (ma >> d)));
        end
        if (s == 0) begin
            r.v = 32'h0;
            return r;
        end
        neg = (s < 0);
        mag = neg ? -s : s;
        while (mag >= 64'd16777216) begin mag = mag >> 1; e++; end
        while (mag < 64'd8388608)   begin mag = mag << 1; e--; end
        if (e >= 255)      r.v = neg ? 32'hFF800000 : 32'h7F800000;
        else if (e <= 0) begin r.v = {neg, 31'd0}; r.uf = 1'b1; end
        else               r.v = {neg, 8'(e), 23'(mag)};
        return r;
    endfunction

    function automatic logic [31:0] gen_term();
        int unsigned k = $urandom_range(0, 99);
        logic        s = 1'($urandom);
        logic [22:0] f = 23'($urandom);
        logic [7:0]  e;
        if (k < 6)       e = 8'd0;
        else if (k < 10) begin e = 8'hFF; f = 23'd0; end
        else if (k < 13) begin e = 8'hFF; f = f | 23'd1; end
        else if (k < 18) e = 8'($urandom_range(248, 254));
        else if (k < 23) e = 8'($urandom_range(1, 4));
        else             e = 8'($urandom_range(118, 136));
        return {s, e, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        int n = 0;
        while (in_ready !== 1'b1 && n < 60) begin tick(); n++; end
        if (in_ready !== 1'b1) check("send_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom();
    endtask

    task automatic recv(input string name, input logic [31:0] exp, input int hold, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin tick(); lat++; end
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(name, out_data, exp);
`ifdef FP32_ACC_FLAGS_EN
        cap_fl = {out_nan, out_inf, out_uf};
`else
        cap_fl = 3'b000;
`endif
        for (int k = 0; k < hold; k++) begin
            tick();
            check({name, "_hold"}, out_data, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [NT-1:0][31:0] t;
        logic [31:0]         res;
        logic [2:0]          fl;   // {nan, inf, uf}
        logic [2:0]          msk;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          lat;
        logic [31:0] acc;
        logic [31:0] terms[NT];
        logic [2:0]  mfl;
        ref_t        rr;

        tbl[0] = '{t: {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000},
                   res: 32'h41200000, fl: 3'b000, msk: 3'b111};
        tbl[1] = '{t: {32'h00000000, 32'h00000000, 32'hBFC00000, 32'h3FC00000},
                   res: 32'h00000000, fl: 3'b000, msk: 3'b111};
        tbl[2] = '{t: {32'h33800000, 32'h33800000, 32'h33800000, 32'h3F800000},
                   res: 32'h3F800000, fl: 3'b000, msk: 3'b111};
        tbl[3] = '{t: {32'h3F800000, 32'h3F800000, 32'hFF800000, 32'h7F800000},
                   res: 32'h7FC00000, fl: 3'b100, msk: 3'b101};
        tbl[4] = '{t: {32'h00000000, 32'h00000000, 32'h80800001, 32'h00800000},
                   res: 32'h80000000, fl: 3'b001, msk: 3'b111};
        tbl[5] = '{t: {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF},
                   res: 32'h7F800000, fl: 3'b010, msk: 3'b111};

        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data,           32'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < NT; j++) send(tbl[i].t[j]);
            recv($sformatf("vec%0d", i), tbl[i].res, 0, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
`ifdef FP32_ACC_FLAGS_EN
            check($sformatf("vec%0d_flags", i), {29'd0, cap_fl & tbl[i].msk},
                  {29'd0, tbl[i].fl & tbl[i].msk});
`endif
        end

        // Overflow result held under back-pressure; input ignored while busy
        for (int j = 0; j < NT; j++) send(32'h7F7FFFFF);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin tick(); lat++; end
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid",    {31'd0, out_valid}, 32'd1);
            check("bp_data",     out_data,           32'h7F800000);
            check("bp_in_ready", {31'd0, in_ready},  32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_after_valid", {31'd0, out_valid}, 32'd0);
        check("bp_after_ready", {31'd0, in_ready},  32'd1);
        for (int j = 0; j < NT; j++) send(32'h3F800000);
        recv("bp_next", 32'h40800000, 0, lat);

        // Reset while the third term sits in ADD
        for (int j = 0; j < 3; j++) send(32'h40400000);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        #1;
        rst = 1'b0;
        for (int j = 0; j < NT; j++) send(32'h3F800000);
        recv("midrst_sum", 32'h40800000, 0, lat);

        // Randomized dot products against the reference model
        for (int r = 0; r < 40; r++) begin
            acc = 32'h0;
            mfl = 3'b000;
            for (int j = 0; j < NT; j++) begin
                terms[j] = gen_term();
                rr  = ref_add(acc, terms[j]);
                acc = rr.v;
                mfl[2] = mfl[2] | ((acc[30:23] == 8'hFF) && (acc[22:0] != 0));
                mfl[1] = mfl[1] | ((acc[30:23] == 8'hFF) && (acc[22:0] == 0));
                mfl[0] = mfl[0] | rr.uf;
            end
            for (int j = 0; j < NT; j++) send(terms[j]);
            recv($sformatf("rnd%0d", r), acc, int'($urandom_range(0, 3)), lat);
`ifdef FP32_ACC_FLAGS_EN
            check($sformatf("rnd%0d_flags", r), {29'd0, cap_fl}, {29'd0, mfl});
`endif
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
